// File: rtl/mem_access_stage_pkg.sv
// Package mem_defs: shared definitions for the MEM pipeline stage.
//  - MEM_OP_* encodings of the memory operation carried from EXE
//  - DATA_SIZE_* encodings of the SRAM transfer size
//  - mem_state_e: request/response state of the stage
//  - PC_RESET_DEFAULT: default reset value of the stage PC
//  - helpers mapping a memory op to its transfer size and load/store class
package mem_defs;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'hbfc00000;

    localparam logic [3:0] MEM_OP_NONE = 4'b0000;
    localparam logic [3:0] MEM_OP_LB   = 4'b0001;
    localparam logic [3:0] MEM_OP_LBU  = 4'b0010;
    localparam logic [3:0] MEM_OP_LH   = 4'b0011;
    localparam logic [3:0] MEM_OP_LHU  = 4'b0100;
    localparam logic [3:0] MEM_OP_LW   = 4'b0101;
    localparam logic [3:0] MEM_OP_SB   = 4'b1000;
    localparam logic [3:0] MEM_OP_SH   = 4'b1001;
    localparam logic [3:0] MEM_OP_SW   = 4'b1010;

    localparam logic [1:0] DATA_SIZE_BYTE = 2'd0;
    localparam logic [1:0] DATA_SIZE_HALF = 2'd1;
    localparam logic [1:0] DATA_SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } mem_state_e;

    // SRAM transfer size for a memory op; word for anything not byte/half.
    function automatic logic [1:0] mem_op_size(input logic [3:0] op);
        logic [1:0] size;
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: size = DATA_SIZE_BYTE;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: size = DATA_SIZE_HALF;
            default:                          size = DATA_SIZE_WORD;
        endcase
        return size;
    endfunction

    // Loads are the non-zero ops with the store bit (bit 3) clear.
    function automatic logic mem_op_is_load(input logic [3:0] op);
        return (op != MEM_OP_NONE) && (op[3] == 1'b0);
    endfunction

    // Stores all carry bit 3.
    function automatic logic mem_op_is_store(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational data lane steering for the MEM stage.
//  Loads : selects the addressed byte/half of rdata and sign/zero extends it.
//  Stores: replicates the low byte (x4) or low half (x2) of rdata so the
//          SRAM sees the store value on every lane; addr_lo is ignored.
//  Ports : rdata   in  32  source word (read data or store source value)
//          addr_lo in  2   byte offset within the word
//          mem_op  in  4   memory op encoding (mem_defs::MEM_OP_*)
//          wdata   out 32  aligned / replicated result
module load_align
    import mem_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  mem_op,
    output logic [31:0] wdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word out of the source word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend for loads, replicate for stores, pass through otherwise.
    always_comb begin
        case (mem_op)
            MEM_OP_LB:  wdata = {{24{byte_s[7]}}, byte_s};
            MEM_OP_LBU: wdata = {24'h000000, byte_s};
            MEM_OP_LH:  wdata = {{16{half_s[15]}}, half_s};
            MEM_OP_LHU: wdata = {16'h0000, half_s};
            MEM_OP_LW:  wdata = rdata;
            MEM_OP_SB:  wdata = {4{rdata[7:0]}};
            MEM_OP_SH:  wdata = {2{rdata[15:0]}};
            MEM_OP_SW:  wdata = rdata;
            default:    wdata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline.
//  Accepts one instruction from EXE over a valid/allowin handshake, issues at
//  most one data-SRAM request (req/addr_ok/data_ok), aligns load data and
//  holds the result until WB accepts it. Non-memory instructions pass through
//  in one cycle. flush kills the in-flight instruction; a request already on
//  the bus is completed and its response drained before new work is taken.
//  Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   exe_*                      instruction fields from EXE
//   mem_allowin                stage can accept from EXE this cycle
//   flush                      kill stage contents
//   data_req/wr/size/addr/wdata, data_addr_ok/data_ok/rdata   SRAM port
//   wb_allowin, mem_to_wb_valid, mem_pc/inst/rf_wen/rf_waddr/rf_wdata   to WB
module mem_access_stage
    import mem_defs::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_to_mem_valid,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_inst,
    input  logic [31:0] exe_result,
    input  logic [3:0]  exe_rf_wen,
    input  logic [4:0]  exe_rf_waddr,
    input  logic [3:0]  exe_mem_op,
    input  logic [31:0] exe_st_data,
    output logic        mem_allowin,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_inst,
    output logic [3:0]  mem_rf_wen,
    output logic [4:0]  mem_rf_waddr,
    output logic [31:0] mem_rf_wdata
);

    mem_state_e  state_q,    state_d;
    logic        valid_q,    valid_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] inst_q,     inst_d;
    logic [3:0]  rf_wen_q,   rf_wen_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [3:0]  mem_op_q,   mem_op_d;
    logic [31:0] addr_q,     addr_d;
    logic [1:0]  size_q,     size_d;
    logic        wr_q,       wr_d;
    logic [31:0] st_wdata_q, st_wdata_d;

    logic        ready_go_s;
    logic        drain_s;
    logic        allowin_s;
    logic        capture_s;
    logic        to_wb_valid_s;
    logic        wb_fire_s;
    logic [31:0] load_wdata_s;
    logic [31:0] store_wdata_s;

    // Read data steering for the instruction held in the stage.
    load_align u_load_align (
        .rdata   (data_rdata),
        .addr_lo (addr_q[1:0]),
        .mem_op  (mem_op_q),
        .wdata   (load_wdata_s)
    );

    // Store lane replication, computed from EXE so it is registered on capture.
    load_align u_store_lanes (
        .rdata   (exe_st_data),
        .addr_lo (exe_result[1:0]),
        .mem_op  (exe_mem_op),
        .wdata   (store_wdata_s)
    );

    // Handshake terms. drain_s covers a killed request still on the bus
    // (REQ with valid cleared) and the wait for its discarded response:
    // the stage must not take new work until the SRAM side is idle.
    always_comb begin
        ready_go_s    = (state_q == ST_IDLE) || (state_q == ST_DONE);
        drain_s       = (state_q == ST_CANCEL) || ((state_q == ST_REQ) && !valid_q);
        allowin_s     = drain_s ? 1'b0 : (!valid_q || (ready_go_s && wb_allowin));
        capture_s     = allowin_s && exe_to_mem_valid && !flush;
        to_wb_valid_s = valid_q && ready_go_s && !flush;
        wb_fire_s     = to_wb_valid_s && wb_allowin;
    end

    // Next-state and next-data computation for every register of the stage.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        rf_wen_d   = rf_wen_q;
        rf_waddr_d = rf_waddr_q;
        wdata_d    = wdata_q;
        mem_op_d   = mem_op_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wr_d       = wr_q;
        st_wdata_d = st_wdata_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (capture_s) begin
            valid_d = 1'b1;
        end else if (wb_fire_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // Request fields are frozen from capture until the next capture,
        // which keeps them stable while waiting for addr_ok.
        if (capture_s) begin
            pc_d       = exe_pc;
            inst_d     = exe_inst;
            rf_wen_d   = exe_rf_wen;
            rf_waddr_d = exe_rf_waddr;
            wdata_d    = exe_result;
            mem_op_d   = exe_mem_op;
            addr_d     = exe_result;
            size_d     = mem_op_size(exe_mem_op);
            wr_d       = mem_op_is_store(exe_mem_op);
            st_wdata_d = store_wdata_s;
        end else if ((state_q == ST_WAIT) && data_data_ok && !flush
                     && mem_op_is_load(mem_op_q)) begin
            wdata_d = load_wdata_s;
        end else begin
            wdata_d = wdata_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    state_d = (exe_mem_op != MEM_OP_NONE) ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A killed request is still completed on the bus; its
                // response is then swallowed in CANCEL.
                if (data_addr_ok) begin
                    state_d = (flush || !valid_q) ? ST_CANCEL : ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A response arriving with the flush needs no draining.
                if (flush) begin
                    state_d = data_data_ok ? ST_IDLE : ST_CANCEL;
                end else if (data_data_ok) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (capture_s) begin
                    state_d = (exe_mem_op != MEM_OP_NONE) ? ST_REQ : ST_IDLE;
                end else if (wb_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_CANCEL: begin
                state_d = data_data_ok ? ST_IDLE : ST_CANCEL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage FSM and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            pc_q       <= PC_RESET;
            inst_q     <= 32'h00000000;
            rf_wen_q   <= 4'h0;
            rf_waddr_q <= 5'd0;
            wdata_q    <= 32'h00000000;
            mem_op_q   <= MEM_OP_NONE;
            addr_q     <= 32'h00000000;
            size_q     <= 2'd0;
            wr_q       <= 1'b0;
            st_wdata_q <= 32'h00000000;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            wdata_q    <= wdata_d;
            mem_op_q   <= mem_op_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wr_q       <= wr_d;
            st_wdata_q <= st_wdata_d;
        end
    end

    assign mem_allowin     = allowin_s;
    assign data_req        = (state_q == ST_REQ);
    assign data_wr         = wr_q;
    assign data_size       = size_q;
    assign data_addr       = addr_q;
    assign data_wdata      = st_wdata_q;
    assign mem_to_wb_valid = to_wb_valid_s;
    assign mem_pc          = pc_q;
    assign mem_inst        = inst_q;
    assign mem_rf_wen      = rf_wen_q;
    assign mem_rf_waddr    = rf_waddr_q;
    assign mem_rf_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, hand
// sequences for stall/flush/backpressure, and a randomized run against a
// behavioural model (expected writeback queue + SRAM with random latency).
module tb_mem_access_stage;
    import mem_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_to_mem_valid;
    logic [31:0] exe_pc, exe_inst, exe_result, exe_st_data;
    logic [3:0]  exe_rf_wen, exe_mem_op;
    logic [4:0]  exe_rf_waddr;
    logic        mem_allowin, flush;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_allowin, mem_to_wb_valid;
    logic [31:0] mem_pc, mem_inst, mem_rf_wdata;
    logic [3:0]  mem_rf_wen;
    logic [4:0]  mem_rf_waddr;

    mem_access_stage #(.PC_RESET(32'hbfc00000)) dut (
        .clk(clk), .reset(reset),
        .exe_to_mem_valid(exe_to_mem_valid), .exe_pc(exe_pc), .exe_inst(exe_inst),
        .exe_result(exe_result), .exe_rf_wen(exe_rf_wen), .exe_rf_waddr(exe_rf_waddr),
        .exe_mem_op(exe_mem_op), .exe_st_data(exe_st_data), .mem_allowin(mem_allowin),
        .flush(flush), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc), .mem_inst(mem_inst),
        .mem_rf_wen(mem_rf_wen), .mem_rf_waddr(mem_rf_waddr), .mem_rf_wdata(mem_rf_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: condition not met", name);
    endtask

    // ---------------- behavioural model ----------------
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_word = 32'h0;

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return ovr_en ? ovr_word : (w * 32'h9E3779B9 + 32'h0BADF00D);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a, input logic [3:0] op);
        logic [31:0] v;
        v = w;
        if (op == MEM_OP_LB || op == MEM_OP_LBU) begin
            v = (w >> (8 * a)) & 32'h000000FF;
            if (op == MEM_OP_LB && v >= 32'd128) v = v | 32'hFFFFFF00;
        end else if (op == MEM_OP_LH || op == MEM_OP_LHU) begin
            v = (w >> (16 * a[1])) & 32'h0000FFFF;
            if (op == MEM_OP_LH && v >= 32'd32768) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] d, input logic [3:0] op);
        if (op == MEM_OP_SB) return (d & 32'hFF) * 32'h01010101;
        if (op == MEM_OP_SH) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [1:0] ref_size(input logic [3:0] op);
        if (op == MEM_OP_LB || op == MEM_OP_LBU || op == MEM_OP_SB) return 2'd0;
        if (op == MEM_OP_LH || op == MEM_OP_LHU || op == MEM_OP_SH) return 2'd1;
        return 2'd2;
    endfunction

    typedef struct {
        logic [31:0] pc, inst, result, st, exp_wdata;
        logic [3:0]  op, wen;
        logic [4:0]  waddr;
    } instr_t;

    instr_t wb_q[$];
    instr_t cur;

    // SRAM model state
    int          aok_delay = 0, dok_delay = 0, req_cnt = 0, pend_cnt = 0;
    logic        pend = 1'b0, rand_lat = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    // samples of the last completed cycle
    logic        s_cap, s_wbv, s_wbfire, s_req, s_allowin, s_afire, s_dok;
    logic [31:0] s_addr, last_wb_wdata, last_dw;
    logic [3:0]  last_wb_wen;
    logic [1:0]  last_size;
    logic        last_wr;
    int          wb_count = 0, afire_count = 0;

    // One clock: sample and score at negedge, then drive SRAM responses.
    task automatic tick();
        instr_t e;
        @(negedge clk);
        s_cap     = mem_allowin & exe_to_mem_valid & !flush;
        s_wbv     = mem_to_wb_valid;
        s_wbfire  = mem_to_wb_valid & wb_allowin;
        s_req     = data_req;
        s_addr    = data_addr;
        s_allowin = mem_allowin;
        s_afire   = data_req & data_addr_ok;
        s_dok     = data_data_ok;
        if (s_wbfire) begin
            if (wb_q.size() == 0) begin
                fail_now("wb_unexpected");
            end else begin
                e = wb_q.pop_front();
                chk("wb_pc", mem_pc, e.pc);
                chk("wb_inst", mem_inst, e.inst);
                chk("wb_wen", {28'h0, mem_rf_wen}, {28'h0, e.wen});
                chk("wb_waddr", {27'h0, mem_rf_waddr}, {27'h0, e.waddr});
                chk("wb_wdata", mem_rf_wdata, e.exp_wdata);
            end
            last_wb_wdata = mem_rf_wdata;
            last_wb_wen   = mem_rf_wen;
            wb_count++;
        end
        if (s_req && cur.op == MEM_OP_NONE) fail_now("req_for_alu_op");
        if (s_afire) begin
            chk("req_addr", data_addr, cur.result);
            chk("req_wr", {31'h0, data_wr}, {31'h0, cur.op[3]});
            chk("req_size", {30'h0, data_size}, {30'h0, ref_size(cur.op)});
            if (cur.op[3]) chk("req_wdata", data_wdata, ref_store(cur.st, cur.op));
            last_size = data_size;
            last_wr   = data_wr;
            last_dw   = data_wdata;
            afire_count++;
        end
        if (flush) wb_q.delete();
        if (s_cap) begin
            cur.pc = exe_pc; cur.inst = exe_inst; cur.result = exe_result;
            cur.st = exe_st_data; cur.op = exe_mem_op; cur.wen = exe_rf_wen;
            cur.waddr = exe_rf_waddr;
            cur.exp_wdata = (exe_mem_op != MEM_OP_NONE && !exe_mem_op[3])
                          ? ref_load(sram_word(exe_result), exe_result[1:0], exe_mem_op)
                          : exe_result;
            wb_q.push_back(cur);
        end
        if (s_dok) pend = 1'b0;
        else if (pend && pend_cnt > 0) pend_cnt--;
        if (s_afire) begin
            pend = 1'b1; pend_cnt = dok_delay; req_cnt = 0; pend_addr = data_addr;
            if (rand_lat) begin
                aok_delay = $urandom_range(0, 3);
                dok_delay = $urandom_range(0, 3);
            end
        end else if (s_req) begin
            req_cnt++;
        end
        @(posedge clk);
        #1;
        data_addr_ok = data_req && (req_cnt >= aok_delay);
        data_data_ok = pend && (pend_cnt == 0);
        data_rdata   = data_data_ok ? sram_word(pend_addr) : $urandom;
    endtask

    // Present an instruction and hold it until captured (bounded).
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                         input logic [31:0] pc, input logic [4:0] waddr);
        int k;
        exe_to_mem_valid = 1'b1;
        exe_mem_op = op; exe_result = addr; exe_st_data = st; exe_pc = pc;
        exe_inst = pc ^ 32'h00A50000; exe_rf_waddr = waddr;
        exe_rf_wen = op[3] ? 4'h0 : 4'hF;
        k = 0;
        do begin tick(); k++; end while (!s_cap && k < 30);
        exe_to_mem_valid = 1'b0;
        if (!s_cap) fail_now("issue_accept_timeout");
    endtask

    task automatic wait_wb(input int wbc0, output int cycles);
        cycles = 0;
        while (wb_count == wbc0 && cycles < 40) begin tick(); cycles++; end
        if (wb_count == wbc0) fail_now("wb_timeout");
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, st, rdata, exp_rf;
        logic [1:0]  exp_size;
        logic [31:0] exp_dw;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int k, wbc0, afc0;
        logic [3:0] ops[9];

        vecs[0]  = '{MEM_OP_NONE, 32'h00001234, 32'h0,        32'h0,        32'h00001234, 2'd2, 32'h0};
        vecs[1]  = '{MEM_OP_LB,   32'h00001002, 32'h0,        32'h80FF7F00, 32'hFFFFFFFF, 2'd0, 32'h0};
        vecs[2]  = '{MEM_OP_LBU,  32'h00001002, 32'h0,        32'h80FF7F00, 32'h000000FF, 2'd0, 32'h0};
        vecs[3]  = '{MEM_OP_LB,   32'h00001003, 32'h0,        32'h80FF7F00, 32'hFFFFFF80, 2'd0, 32'h0};
        vecs[4]  = '{MEM_OP_LB,   32'h00001001, 32'h0,        32'h80FF7F00, 32'h0000007F, 2'd0, 32'h0};
        vecs[5]  = '{MEM_OP_LH,   32'h00001002, 32'h0,        32'h80FF7F00, 32'hFFFF80FF, 2'd1, 32'h0};
        vecs[6]  = '{MEM_OP_LHU,  32'h00001002, 32'h0,        32'h80FF7F00, 32'h000080FF, 2'd1, 32'h0};
        vecs[7]  = '{MEM_OP_LH,   32'h00001000, 32'h0,        32'h80FF7F00, 32'h00007F00, 2'd1, 32'h0};
        vecs[8]  = '{MEM_OP_LW,   32'h00001000, 32'h0,        32'h80FF7F00, 32'h80FF7F00, 2'd2, 32'h0};
        vecs[9]  = '{MEM_OP_SB,   32'h00002001, 32'h123456AB, 32'h0,        32'h00002001, 2'd0, 32'hABABABAB};
        vecs[10] = '{MEM_OP_SH,   32'h00002002, 32'h0000BEEF, 32'h0,        32'h00002002, 2'd1, 32'hBEEFBEEF};
        vecs[11] = '{MEM_OP_SW,   32'h00002000, 32'hCAFEF00D, 32'h0,        32'h00002000, 2'd2, 32'hCAFEF00D};
        ops = '{MEM_OP_NONE, MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU,
                MEM_OP_LW, MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};

        cur = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 5'd0};
        reset = 1'b1; exe_to_mem_valid = 1'b0; exe_pc = 32'h0; exe_inst = 32'h0;
        exe_result = 32'h0; exe_rf_wen = 4'h0; exe_rf_waddr = 5'd0; exe_mem_op = 4'h0;
        exe_st_data = 32'h0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'h0; wb_allowin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_pc", mem_pc, 32'hbfc00000);
        chk("rst_wb_valid", {31'h0, mem_to_wb_valid}, 32'h0);
        chk("rst_data_req", {31'h0, data_req}, 32'h0);
        chk("rst_allowin", {31'h0, mem_allowin}, 32'h1);
        chk("rst_rf_wdata", mem_rf_wdata, 32'h0);
        chk("rst_data_addr", data_addr, 32'h0);
        reset = 1'b0;

        // ---- directed vector table ----
        ovr_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ovr_word = vecs[i].rdata;
            wbc0 = wb_count; afc0 = afire_count;
            issue(vecs[i].op, vecs[i].addr, vecs[i].st, 32'h80000000 + 32'(i * 4), 5'(i + 1));
            wait_wb(wbc0, k);
            if (vecs[i].op == MEM_OP_NONE) begin
                chk($sformatf("v%0d_alu_latency", i), k, 32'd1);
                chk($sformatf("v%0d_no_req", i), afire_count - afc0, 32'd0);
            end else begin
                chk($sformatf("v%0d_one_req", i), afire_count - afc0, 32'd1);
                chk($sformatf("v%0d_size", i), {30'h0, last_size}, {30'h0, vecs[i].exp_size});
                chk($sformatf("v%0d_wr", i), {31'h0, last_wr}, {31'h0, vecs[i].op[3]});
            end
            chk($sformatf("v%0d_rf_wdata", i), last_wb_wdata, vecs[i].exp_rf);
            if (vecs[i].op[3]) begin
                chk($sformatf("v%0d_st_wdata", i), last_dw, vecs[i].exp_dw);
                chk($sformatf("v%0d_st_wen", i), {28'h0, last_wb_wen}, 32'h0);
            end
        end

        // ---- addr_ok held low for 3 cycles ----
        aok_delay = 3; dok_delay = 0; ovr_word = 32'h0BADCAFE;
        wbc0 = wb_count;
        issue(MEM_OP_LW, 32'h00000100, 32'h0, 32'h80001000, 5'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req", {31'h0, s_req}, 32'h1);
            chk("stall_addr", s_addr, 32'h00000100);
            chk("stall_allowin", {31'h0, s_allowin}, 32'h0);
            chk("stall_aok_cycle", {31'h0, s_afire}, (i == 3) ? 32'h1 : 32'h0);
        end
        wait_wb(wbc0, k);
        chk("stall_result", last_wb_wdata, 32'h0BADCAFE);
        aok_delay = 0;

        // ---- flush in WAIT, response drained two cycles later ----
        dok_delay = 2; ovr_word = 32'h0000DEAD;
        wbc0 = wb_count;
        issue(MEM_OP_LW, 32'h00000200, 32'h0, 32'h80002000, 5'd4);
        k = 0;
        while (!s_afire && k < 20) begin tick(); k++; end
        if (!s_afire) fail_now("flush_req_timeout");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_wb_valid", {31'h0, s_wbv}, 32'h0);
        chk("flush_allowin", {31'h0, s_allowin}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drain_allowin", {31'h0, s_allowin}, 32'h0);
            chk("drain_wb_valid", {31'h0, s_wbv}, 32'h0);
            chk("drain_dok", {31'h0, s_dok}, (i == 1) ? 32'h1 : 32'h0);
        end
        tick();
        chk("drain_done_allowin", {31'h0, s_allowin}, 32'h1);
        chk("flush_no_wb", wb_count - wbc0, 32'd0);
        dok_delay = 0; ovr_word = 32'h13579BDF;
        wbc0 = wb_count;
        issue(MEM_OP_LW, 32'h00000204, 32'h0, 32'h80002004, 5'd5);
        wait_wb(wbc0, k);
        chk("post_flush_lw", last_wb_wdata, 32'h13579BDF);

        // ---- backpressure in DONE, back-to-back LW on release ----
        wb_allowin = 1'b0; aok_delay = 1; dok_delay = 1; ovr_word = 32'hA5A51234;
        issue(MEM_OP_LW, 32'h00000300, 32'h0, 32'h80003000, 5'd7);
        k = 0;
        while (!s_wbv && k < 30) begin tick(); k++; end
        chk("bp_reach_done", {31'h0, s_wbv}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_wb_valid", {31'h0, s_wbv}, 32'h1);
            chk("bp_allowin", {31'h0, s_allowin}, 32'h0);
            chk("bp_rf_wdata", mem_rf_wdata, 32'hA5A51234);
            chk("bp_pc", mem_pc, 32'h80003000);
            chk("bp_waddr", {27'h0, mem_rf_waddr}, 32'd7);
        end
        wb_allowin = 1'b1; aok_delay = 0; dok_delay = 0;
        exe_to_mem_valid = 1'b1; exe_mem_op = MEM_OP_LW; exe_result = 32'h00000304;
        exe_pc = 32'h80003004; exe_inst = 32'h8C000304; exe_rf_waddr = 5'd8; exe_rf_wen = 4'hF;
        wbc0 = wb_count;
        tick();
        exe_to_mem_valid = 1'b0;
        chk("b2b_wb_fire", {31'h0, s_wbfire}, 32'h1);
        chk("b2b_capture", {31'h0, s_cap}, 32'h1);
        tick();
        chk("b2b_req_next", {31'h0, s_req}, 32'h1);
        wait_wb(wbc0 + 1, k);

        // ---- randomized run against the model ----
        ovr_en = 1'b0; rand_lat = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (!exe_to_mem_valid || s_cap || flush) begin
                exe_mem_op = ops[$urandom_range(0, 8)];
                exe_result = $urandom;
                if (exe_mem_op == MEM_OP_LH || exe_mem_op == MEM_OP_LHU || exe_mem_op == MEM_OP_SH)
                    exe_result[0] = 1'b0;
                else if (exe_mem_op == MEM_OP_LW || exe_mem_op == MEM_OP_SW)
                    exe_result[1:0] = 2'b00;
                exe_st_data = $urandom; exe_pc = $urandom; exe_inst = $urandom;
                exe_rf_waddr = 5'($urandom_range(0, 31));
                exe_rf_wen = exe_mem_op[3] ? 4'h0 : 4'hF;
                exe_to_mem_valid = ($urandom_range(0, 3) != 0);
            end
            flush = ($urandom_range(0, 39) == 0);
            wb_allowin = ($urandom_range(0, 3) != 0);
            tick();
        end
        flush = 1'b0; exe_to_mem_valid = 1'b0; wb_allowin = 1'b1;
        k = 0;
        while ((wb_q.size() != 0 || pend || data_req) && k < 60) begin tick(); k++; end
        chk("rand_drain_queue", wb_q.size(), 32'd0);
        chk("rand_drain_pending", {31'h0, pend}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
